// File: rtl/uart_cmd_receiver_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : uart_cmd_receiver_pkg                                   |
// | Purpose  : Shared constants, state encodings and checksum helper   |
// |            for the inbound ground-station UART command path.       |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
package uart_cmd_receiver_pkg;

   localparam logic [7:0]  c_sync_byte  = 8'hA5;
   localparam logic [7:0]  c_srst_addr  = 8'hFF;
   localparam logic [15:0] c_srst_key   = 16'hDEAD;
   localparam int          c_cmd_addr_w = 8;
   localparam int          c_cmd_data_w = 16;

   // Byte receiver states
   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_t;

   // Frame parser states; the name is the byte position expected next
   typedef enum logic [2:0] {
      P_HUNT = 3'd0,
      P_ADDR = 3'd1,
      P_DHI  = 3'd2,
      P_DLO  = 3'd3,
      P_CSUM = 3'd4
   } parse_state_t;

   // Frame checksum covers the three payload bytes only, not the sync byte
   function automatic logic [7:0] frame_csum(input logic [7:0] addr,
                                             input logic [7:0] dhi,
                                             input logic [7:0] dlo);
      return addr ^ dhi ^ dlo;
   endfunction

endpackage : uart_cmd_receiver_pkg
`default_nettype wire

// File: rtl/uart_cmd_receiver_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : uart_cmd_receiver_if                                    |
// | Purpose  : Command-side outputs of the UART command receiver:      |
// |            byte strobe, command strobe, error strobe, soft reset.  |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
interface uart_cmd_receiver_if;
   import uart_cmd_receiver_pkg::*;

   logic                    rxrdy_n;
   logic                    cmd_valid;
   logic [c_cmd_addr_w-1:0] cmd_addr;
   logic [c_cmd_data_w-1:0] cmd_data;
   logic                    frame_err;
   logic                    soft_reset_n;

   // Receiver side drives everything
   modport master (
      output rxrdy_n,
      output cmd_valid,
      output cmd_addr,
      output cmd_data,
      output frame_err,
      output soft_reset_n
   );

   // Register file / reset controller side
   modport slave (
      input rxrdy_n,
      input cmd_valid,
      input cmd_addr,
      input cmd_data,
      input frame_err,
      input soft_reset_n
   );

endinterface : uart_cmd_receiver_if
`default_nettype wire

// File: rtl/uart_rx_byte.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : uart_rx_byte                                            |
// | Purpose  : 8N1 byte deserialiser with input synchroniser. Emits a  |
// |            1-cycle rx_done for a good byte or rx_ferr for a bad    |
// |            stop bit.                                               |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module uart_rx_byte
   import uart_cmd_receiver_pkg::*;
#(
   parameter int CLKS_PER_BIT = 330
) (
   input  logic       sys_clk,
   input  logic       resetn,
   input  logic       sin,
   output logic [7:0] rx_byte,
   output logic       rx_done,
   output logic       rx_ferr
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] c_bit_last  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] c_half_last = CW'(CLKS_PER_BIT / 2 - 1);

   logic [1:0]    r_sync;
   logic          r_sin_prev;
   logic          w_sin_s;
   logic          w_fall;

   rx_state_t     r_state;
   rx_state_t     w_state_nxt;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nxt;
   logic [CW-1:0] w_cnt_inc;
   logic [2:0]    r_bit_idx;
   logic [2:0]    w_bit_nxt;
   logic [7:0]    r_shreg;
   logic [7:0]    w_shreg_nxt;
   logic          r_done;
   logic          w_done_nxt;
   logic          r_ferr;
   logic          w_ferr_nxt;

   // Two-flop synchroniser plus edge history, preset to the idle-high line level
   always_ff @(posedge sys_clk or negedge resetn) begin
      if (!resetn) begin
         r_sync     <= 2'b11;
         r_sin_prev <= 1'b1;
      end else begin
         r_sync     <= {r_sync[0], sin};
         r_sin_prev <= r_sync[1];
      end
   end

   assign w_sin_s = r_sync[1];
   assign w_fall  = r_sin_prev & ~w_sin_s;

   // Bit-period counter saturates rather than wrapping
   assign w_cnt_inc = (r_cnt == c_bit_last) ? r_cnt : r_cnt + CW'(1);

   // State register
   always_ff @(posedge sys_clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= RX_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Datapath registers: bit timer, bit index, shift register and result strobes
   always_ff @(posedge sys_clk or negedge resetn) begin
      if (!resetn) begin
         r_cnt     <= '0;
         r_bit_idx <= '0;
         r_shreg   <= '0;
         r_done    <= 1'b0;
         r_ferr    <= 1'b0;
      end else begin
         r_cnt     <= w_cnt_nxt;
         r_bit_idx <= w_bit_nxt;
         r_shreg   <= w_shreg_nxt;
         r_done    <= w_done_nxt;
         r_ferr    <= w_ferr_nxt;
      end
   end

   // Next-state logic: midpoint sampling, LSB first, leave STOP at its midpoint
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_bit_nxt   = r_bit_idx;
      w_shreg_nxt = r_shreg;
      w_done_nxt  = 1'b0;
      w_ferr_nxt  = 1'b0;
      case (r_state)
         RX_IDLE: begin
            if (w_fall) begin
               w_state_nxt = RX_START;
               w_cnt_nxt   = '0;
            end
         end
         RX_START: begin
            if (r_cnt == c_half_last) begin
               w_cnt_nxt   = '0;
               w_bit_nxt   = '0;
               // A start bit that is high again at its midpoint was a glitch
               w_state_nxt = w_sin_s ? RX_IDLE : RX_DATA;
            end else begin
               w_cnt_nxt = w_cnt_inc;
            end
         end
         RX_DATA: begin
            if (r_cnt == c_bit_last) begin
               w_cnt_nxt   = '0;
               w_shreg_nxt = {w_sin_s, r_shreg[7:1]};
               if (r_bit_idx == 3'd7) begin
                  w_state_nxt = RX_STOP;
               end else begin
                  w_bit_nxt = r_bit_idx + 3'd1;
               end
            end else begin
               w_cnt_nxt = w_cnt_inc;
            end
         end
         RX_STOP: begin
            if (r_cnt == c_bit_last) begin
               w_cnt_nxt   = '0;
               w_state_nxt = RX_IDLE;
               if (w_sin_s) begin
                  w_done_nxt = 1'b1;
               end else begin
                  w_ferr_nxt = 1'b1;
               end
            end else begin
               w_cnt_nxt = w_cnt_inc;
            end
         end
         default: begin
            w_state_nxt = RX_IDLE;
         end
      endcase
   end

   // Shift register is untouched outside DATA, so it is stable while rx_done is high
   assign rx_byte = r_shreg;
   assign rx_done = r_done;
   assign rx_ferr = r_ferr;

endmodule : uart_rx_byte
`default_nettype wire

// File: rtl/uart_cmd_receiver.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : uart_cmd_receiver                                       |
// | Purpose  : Inbound UART command path. Parses 5-byte frames         |
// |            (A5, ADDR, DHI, DLO, CSUM), issues checked register-    |
// |            write strobes, flags errors and drives a soft reset.    |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module uart_cmd_receiver
   import uart_cmd_receiver_pkg::*;
#(
   parameter int CLKS_PER_BIT = 330,
   parameter int TIMEOUT_CLKS = 38000,
   parameter int SRST_CYCLES  = 16
) (
   input  logic                 sys_clk,
   input  logic                 resetn,
   input  logic                 sin,
   uart_cmd_receiver_if.master  cmd_bus
);

   localparam int TW = $clog2(TIMEOUT_CLKS + 1);
   localparam int SW = $clog2(SRST_CYCLES + 1);
   localparam logic [TW-1:0] c_tmo_max  = TW'(TIMEOUT_CLKS);
   localparam logic [SW-1:0] c_srst_len = SW'(SRST_CYCLES);

   logic [7:0]              w_rx_byte;
   logic                    w_rx_done;
   logic                    w_rx_ferr;

   parse_state_t            r_state;
   parse_state_t            w_state_nxt;
   logic [7:0]              r_addr;
   logic [7:0]              w_addr_nxt;
   logic [7:0]              r_dhi;
   logic [7:0]              w_dhi_nxt;
   logic [7:0]              r_dlo;
   logic [7:0]              w_dlo_nxt;
   logic                    w_cmd_fire;
   logic                    w_ferr_fire;

   logic [TW-1:0]           r_tcnt;
   logic [TW-1:0]           w_tcnt_inc;
   logic [TW-1:0]           w_tcnt_nxt;
   logic                    w_timeout;

   logic                    r_cmd_valid;
   logic [c_cmd_addr_w-1:0] r_cmd_addr;
   logic [c_cmd_data_w-1:0] r_cmd_data;
   logic                    r_frame_err;
   logic [SW-1:0]           r_srst_cnt;
   logic                    w_srst_start;

   uart_rx_byte #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_rx_byte (
      .sys_clk (sys_clk),
      .resetn  (resetn),
      .sin     (sin),
      .rx_byte (w_rx_byte),
      .rx_done (w_rx_done),
      .rx_ferr (w_rx_ferr)
   );

   // Inter-byte gap timer: idle in HUNT, cleared by every good byte, saturating
   assign w_tcnt_inc = (r_tcnt == c_tmo_max) ? r_tcnt : r_tcnt + TW'(1);
   assign w_tcnt_nxt = ((r_state == P_HUNT) || w_rx_done) ? '0 : w_tcnt_inc;
   assign w_timeout  = (r_state != P_HUNT) && (w_tcnt_inc == c_tmo_max);

   // Parser state register
   always_ff @(posedge sys_clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= P_HUNT;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Parser next-state: a good byte takes priority over a same-cycle timeout
   always_comb begin
      w_state_nxt = r_state;
      w_addr_nxt  = r_addr;
      w_dhi_nxt   = r_dhi;
      w_dlo_nxt   = r_dlo;
      w_cmd_fire  = 1'b0;
      w_ferr_fire = 1'b0;
      if (w_rx_done) begin
         case (r_state)
            P_HUNT: begin
               if (w_rx_byte == c_sync_byte) begin
                  w_state_nxt = P_ADDR;
               end
            end
            P_ADDR: begin
               w_addr_nxt  = w_rx_byte;
               w_state_nxt = P_DHI;
            end
            P_DHI: begin
               w_dhi_nxt   = w_rx_byte;
               w_state_nxt = P_DLO;
            end
            P_DLO: begin
               w_dlo_nxt   = w_rx_byte;
               w_state_nxt = P_CSUM;
            end
            P_CSUM: begin
               w_state_nxt = P_HUNT;
               if (w_rx_byte == frame_csum(r_addr, r_dhi, r_dlo)) begin
                  w_cmd_fire = 1'b1;
               end else begin
                  w_ferr_fire = 1'b1;
               end
            end
            default: begin
               w_state_nxt = P_HUNT;
            end
         endcase
      end else if ((r_state != P_HUNT) && (w_rx_ferr || w_timeout)) begin
         // Stop-bit errors while hunting are line noise and are dropped silently
         w_ferr_fire = 1'b1;
         w_state_nxt = P_HUNT;
      end
   end

   // Frame capture, gap timer and registered command/error strobes
   always_ff @(posedge sys_clk or negedge resetn) begin
      if (!resetn) begin
         r_addr      <= '0;
         r_dhi       <= '0;
         r_dlo       <= '0;
         r_tcnt      <= '0;
         r_cmd_valid <= 1'b0;
         r_cmd_addr  <= '0;
         r_cmd_data  <= '0;
         r_frame_err <= 1'b0;
      end else begin
         r_addr      <= w_addr_nxt;
         r_dhi       <= w_dhi_nxt;
         r_dlo       <= w_dlo_nxt;
         r_tcnt      <= w_tcnt_nxt;
         r_cmd_valid <= w_cmd_fire;
         r_frame_err <= w_ferr_fire;
         if (w_cmd_fire) begin
            r_cmd_addr <= r_addr;
            r_cmd_data <= {r_dhi, r_dlo};
         end
      end
   end

   // The soft-reset command is recognised from the issued command itself
   assign w_srst_start = r_cmd_valid && (r_cmd_addr == c_srst_addr) &&
                         (r_cmd_data == c_srst_key);

   // Soft-reset pulse length counter; a repeat command reloads it
   always_ff @(posedge sys_clk or negedge resetn) begin
      if (!resetn) begin
         r_srst_cnt <= '0;
      end else if (w_srst_start) begin
         r_srst_cnt <= c_srst_len;
      end else if (r_srst_cnt != '0) begin
         r_srst_cnt <= r_srst_cnt - SW'(1);
      end
   end

   assign cmd_bus.rxrdy_n      = ~w_rx_done;
   assign cmd_bus.cmd_valid    = r_cmd_valid;
   assign cmd_bus.cmd_addr     = r_cmd_addr;
   assign cmd_bus.cmd_data     = r_cmd_data;
   assign cmd_bus.frame_err    = r_frame_err;
   assign cmd_bus.soft_reset_n = (r_srst_cnt == '0);

endmodule : uart_cmd_receiver
`default_nettype wire
